// File: rtl/eeprom_save_bridge.sv
// Bridges the 8 KB EEPROM save array and the host SD sector interface:
// loads every sector on image mount and writes every sector back on a save request.
module eeprom_save_bridge #(
    parameter int MEM_AW      = 13,
    parameter int SECTOR_AW   = 9,
    parameter int NUM_SECTORS = 2 ** (MEM_AW - SECTOR_AW)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    input  logic                 eeprom_wr,
    input  logic                 img_mounted,
    input  logic [31:0]          img_size,
    input  logic                 save_req,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [SECTOR_AW-1:0] sd_buff_addr,
    input  logic [7:0]           sd_buff_dout,
    output logic [7:0]           sd_buff_din,
    input  logic                 sd_buff_wr,
    output logic                 busy,
    output logic                 dirty
);
    localparam int SEC_W = MEM_AW - SECTOR_AW;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_REQ  = 3'd1;
    localparam logic [2:0] LOAD_XFER = 3'd2;
    localparam logic [2:0] SAVE_REQ  = 3'd3;
    localparam logic [2:0] SAVE_XFER = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [SEC_W-1:0]  sector_reg, sector_next;
    logic              sd_rd_reg, sd_rd_next;
    logic              sd_wr_reg, sd_wr_next;
    logic              dirty_reg, dirty_next;
    logic              ack_prev_reg;
    logic              mem_we_reg;
    logic [MEM_AW-1:0] mem_waddr_reg;
    logic [7:0]        mem_wdata_reg;

    logic ack_rise, ack_fall, last_sector;

    assign ack_rise    = sd_ack & ~ack_prev_reg;
    assign ack_fall    = ~sd_ack & ack_prev_reg;
    assign last_sector = (sector_reg == SEC_W'(NUM_SECTORS - 1));

    always_comb begin
        state_next  = state_reg;
        sector_next = sector_reg;
        sd_rd_next  = sd_rd_reg;
        sd_wr_next  = sd_wr_reg;
        dirty_next  = dirty_reg;
        case (state_reg)
            IDLE: begin
                // Mount wins over save when both arrive together; an empty image is ignored.
                if (img_mounted && (img_size != 32'd0)) begin
                    sector_next = '0;
                    sd_rd_next  = 1'b1;
                    state_next  = LOAD_REQ;
                end else if (save_req) begin
                    sector_next = '0;
                    dirty_next  = 1'b0;
                    sd_wr_next  = 1'b1;
                    state_next  = SAVE_REQ;
                end
            end
            LOAD_REQ: begin
                if (ack_rise) begin
                    sd_rd_next = 1'b0;
                    state_next = LOAD_XFER;
                end
            end
            LOAD_XFER: begin
                if (ack_fall) begin
                    if (last_sector) begin
                        dirty_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        sector_next = sector_reg + SEC_W'(1);
                        sd_rd_next  = 1'b1;
                        state_next  = LOAD_REQ;
                    end
                end
            end
            SAVE_REQ: begin
                if (ack_rise) begin
                    sd_wr_next = 1'b0;
                    state_next = SAVE_XFER;
                end
            end
            SAVE_XFER: begin
                if (ack_fall) begin
                    if (last_sector) begin
                        state_next = IDLE;
                    end else begin
                        sector_next = sector_reg + SEC_W'(1);
                        sd_wr_next  = 1'b1;
                        state_next  = SAVE_REQ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A core write in the same cycle as a clear must leave the array marked modified.
        if (eeprom_wr) dirty_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sector_reg    <= '0;
            sd_rd_reg     <= 1'b0;
            sd_wr_reg     <= 1'b0;
            dirty_reg     <= 1'b0;
            ack_prev_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sector_reg   <= sector_next;
            sd_rd_reg    <= sd_rd_next;
            sd_wr_reg    <= sd_wr_next;
            dirty_reg    <= dirty_next;
            ack_prev_reg <= sd_ack;
            mem_we_reg   <= 1'b0;
            if ((state_reg == LOAD_XFER) && sd_ack && sd_buff_wr) begin
                mem_we_reg    <= 1'b1;
                mem_waddr_reg <= {sector_reg, sd_buff_addr};
                mem_wdata_reg <= sd_buff_dout;
            end
        end
    end

    // Saving reads straight through the port so the host sees data one clock after its address.
    assign mem_addr    = ((state_reg == SAVE_XFER) && sd_ack) ? {sector_reg, sd_buff_addr}
                                                              : mem_waddr_reg;
    assign sd_buff_din = (state_reg == SAVE_XFER) ? mem_rdata : 8'd0;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_we      = mem_we_reg;
    assign sd_lba      = {{(32 - SEC_W){1'b0}}, sector_reg};
    assign sd_rd       = sd_rd_reg;
    assign sd_wr       = sd_wr_reg;
    assign busy        = (state_reg != IDLE);
    assign dirty       = dirty_reg;
endmodule

// File: tb/tb_eeprom_save_bridge.sv
// Self-checking bench: host sector model, EEPROM memory model and scoreboard queues
// for requested sector numbers and bytes returned to the host.
module tb_eeprom_save_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        eeprom_wr = 1'b0;
    logic        img_mounted = 1'b0;
    logic [31:0] img_size = 32'd0;
    logic        save_req = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_dout = 8'd0;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr = 1'b0;
    logic        busy;
    logic        dirty;

    eeprom_save_bridge dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .eeprom_wr(eeprom_wr), .img_mounted(img_mounted), .img_size(img_size),
        .save_req(save_req), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .busy(busy), .dirty(dirty)
    );

    always #5 clk = ~clk;

    // EEPROM secondary-port model: registered read, one clock of latency.
    logic [7:0] mem [0:8191];
    int we_count = 0;
    int wr_cycles = 0;
    int both_count = 0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_we) we_count <= we_count + 1;
        if (sd_wr) wr_cycles <= wr_cycles + 1;
        if (sd_rd && sd_wr) both_count <= both_count + 1;
    end

    int n_checks = 0;
    int n_pass = 0;
    int exp_lba_q[$];
    logic [7:0] din_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int k, input int mode);
        logic [12:0] kk;
        kk = 13'(k);
        if (mode == 0) return kk[7:0];
        return kk[7:0] ^ {kk[12:9], kk[12:9]};
    endfunction

    task automatic wait_sig(input bit want_rd, output bit ok);
        int t;
        t = 0;
        while (((want_rd ? sd_rd : sd_wr) !== 1'b1) && t < 50) begin
            tick();
            t++;
        end
        ok = ((want_rd ? sd_rd : sd_wr) === 1'b1);
        if (!ok) check_eq(want_rd ? "sd_rd_timeout" : "sd_wr_timeout", 32'd0, 32'd1);
    endtask

    // Host serves sector n with bytes n ^ addr[7:0].
    task automatic do_load(input int save_at_lba, input int abort_lba);
        bit ok;
        int wc;
        for (int n = 0; n < 16; n++) exp_lba_q.push_back(n);
        for (int n = 0; n < 16; n++) begin
            wait_sig(1'b1, ok);
            if (!ok) begin
                exp_lba_q.delete();
                return;
            end
            check_eq("load_lba", sd_lba, exp_lba_q.pop_front());
            check_eq("load_no_wr", {31'd0, sd_wr}, 32'd0);
            sd_ack = 1'b1;
            tick();
            check_eq("rd_drop", {31'd0, sd_rd}, 32'd0);
            if (n == abort_lba) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_eq("abort_rd", {31'd0, sd_rd}, 32'd0);
                check_eq("abort_wr", {31'd0, sd_wr}, 32'd0);
                check_eq("abort_busy", {31'd0, busy}, 32'd0);
                wc = we_count;
                sd_buff_addr = 9'd5;
                sd_buff_dout = 8'hAA;
                sd_buff_wr = 1'b1;
                tick();
                sd_buff_wr = 1'b0;
                tick();
                check_eq("stray_we", we_count, wc);
                sd_ack = 1'b0;
                tick();
                exp_lba_q.delete();
                return;
            end
            for (int a = 0; a < 512; a++) begin
                sd_buff_addr = 9'(a);
                sd_buff_dout = 8'(n) ^ 8'(a);
                sd_buff_wr = 1'b1;
                save_req = (n == save_at_lba && a == 100);
                tick();
            end
            sd_buff_wr = 1'b0;
            save_req = 1'b0;
            tick();
            sd_ack = 1'b0;
            tick();
        end
        check_eq("load_busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_save(input int mode, input int eewr_lba);
        bit ok;
        logic [7:0] got;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        for (int n = 0; n < 16; n++) exp_lba_q.push_back(n);
        for (int n = 0; n < 16; n++) begin
            wait_sig(1'b0, ok);
            if (!ok) begin
                exp_lba_q.delete();
                return;
            end
            check_eq("save_lba", sd_lba, exp_lba_q.pop_front());
            check_eq("save_no_rd", {31'd0, sd_rd}, 32'd0);
            sd_ack = 1'b1;
            tick();
            check_eq("wr_drop", {31'd0, sd_wr}, 32'd0);
            sd_buff_addr = 9'd0;
            din_q.push_back(pat(n * 512, mode));
            tick();
            for (int a = 1; a <= 512; a++) begin
                got = sd_buff_din;
                check_eq("save_din", {24'd0, got}, {24'd0, din_q.pop_front()});
                if (mode == 0 && n == 3 && a == 512) check_eq("lba3_1ff", {24'd0, got}, 32'hFF);
                if (a < 512) begin
                    sd_buff_addr = 9'(a);
                    din_q.push_back(pat(n * 512 + a, mode));
                end
                eeprom_wr = (n == eewr_lba && a == 200);
                tick();
            end
            eeprom_wr = 1'b0;
            sd_ack = 1'b0;
            tick();
        end
        check_eq("save_busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int wc;
        tick();
        tick();
        check_eq("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
        check_eq("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
        check_eq("rst_sd_lba", sd_lba, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_dirty", {31'd0, dirty}, 32'd0);
        check_eq("rst_din", {24'd0, sd_buff_din}, 32'd0);
        reset = 1'b0;
        tick();

        eeprom_wr = 1'b1;
        tick();
        eeprom_wr = 1'b0;
        check_eq("dirty_set", {31'd0, dirty}, 32'd1);

        img_size = 32'd8192;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        check_eq("load_busy", {31'd0, busy}, 32'd1);
        do_load(-1, -1);
        check_eq("load_dirty", {31'd0, dirty}, 32'd0);
        check_eq("mem_1234", {24'd0, mem[13'h1234]}, 32'h3D);
        check_eq("mem_0000", {24'd0, mem[13'h0000]}, 32'h00);
        check_eq("mem_1fff", {24'd0, mem[13'h1FFF]}, 32'hF0);
        check_eq("mem_0a55", {24'd0, mem[13'h0A55]}, 32'h50);

        for (int k = 0; k < 8192; k++) mem[k] = pat(k, 0);
        wc = we_count;
        do_save(0, -1);
        check_eq("save_no_we", we_count, wc);
        check_eq("save_dirty", {31'd0, dirty}, 32'd0);

        for (int k = 0; k < 8192; k++) mem[k] = pat(k, 1);
        eeprom_wr = 1'b1;
        tick();
        eeprom_wr = 1'b0;
        check_eq("dirty_set2", {31'd0, dirty}, 32'd1);
        do_save(1, 5);
        check_eq("dirty_during_save", {31'd0, dirty}, 32'd1);
        do_save(1, -1);
        check_eq("dirty_clean_save", {31'd0, dirty}, 32'd0);

        img_size = 32'd0;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        tick();
        check_eq("zero_img_busy", {31'd0, busy}, 32'd0);
        check_eq("zero_img_rd", {31'd0, sd_rd}, 32'd0);

        wc = wr_cycles;
        img_size = 32'd8192;
        img_mounted = 1'b1;
        save_req = 1'b1;
        tick();
        img_mounted = 1'b0;
        save_req = 1'b0;
        do_load(2, -1);
        tick();
        tick();
        check_eq("prio_no_wr", wr_cycles, wc);
        check_eq("prio_busy", {31'd0, busy}, 32'd0);

        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        do_load(-1, 7);
        check_eq("never_both", both_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
